imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64: instruction memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of first word written.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a load session.
REQ-006 byte_valid  input  1  byte_data holds a valid byte.
REQ-007 byte_data  input  8  serial program stream byte.
REQ-008 byte_ready  output  1  loader accepts byte this cycle.
REQ-009 wr_en  output  1  instruction memory write strobe.
REQ-010 wr_addr  output  32  instruction memory byte address.
REQ-011 wr_data  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds pipeline (PC, IF/ID) while high.
REQ-013 busy  output  1  load session in progress.
REQ-014 done  output  1  program loaded successfully.
REQ-015 err  output  1  session aborted by error.

Function
REQ-016 Byte transfer SHALL occur only on a cycle with byte_valid=1 and byte_ready=1.
REQ-017 FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
REQ-018 IDLE: start=1 -> LEN_HI, busy=1, cpu_hold=1; start ignored in all other states except DONE and ERR, where it also -> LEN_HI.
REQ-019 LEN_HI/LEN_LO: accepted bytes form 16-bit word count N, high byte first.
REQ-020 After LEN_LO: N=0 -> DONE; N>DEPTH -> ERR; otherwise -> DATA with word index 0.
REQ-021 DATA: bytes assembled big-endian (first byte -> wr_data[31:24]); after 4th accepted byte -> WRITE.
REQ-022 WRITE: wr_en=1 for exactly one cycle, the cycle after the 4th byte is accepted; wr_addr = BASE_ADDR + 4*index; byte_ready=0.
REQ-023 After WRITE: index incremented; index==N -> DONE (or checksum phase, REQ-031), else -> DATA.
REQ-024 byte_ready SHALL be 1 only in LEN_HI, LEN_LO, DATA (and checksum phase).
REQ-025 DONE: done=1, busy=0, cpu_hold=0; held until start or reset.
REQ-026 ERR: err=1, busy=0, cpu_hold=1, no further writes; held until start or reset.
REQ-027 New start SHALL clear done and err in the same cycle LEN_HI is entered.
REQ-028 byte_valid gaps SHALL stall the FSM without losing partial-word state.
REQ-029 Index SHALL never exceed DEPTH-1 when wr_en=1; no address wrap-around.

Reset
REQ-030 reset=0 on a clock edge -> IDLE; byte_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, done=0, err=0, cpu_hold=1; partial word and index discarded, including mid-session.

Configuration
REQ-031 IMEM_LOADER_CHECKSUM_EN defined: after the last word, one extra byte SHALL be accepted and compared to XOR of all data bytes; match -> DONE, mismatch -> ERR (words already written remain).
REQ-032 IMEM_LOADER_CHECKSUM_EN undefined: no checksum byte; after last WRITE -> DONE directly; err set only by N>DEPTH.

Verification
REQ-033 Reset, start, bytes 00 02 20 08 00 05 20 09 00 07 -> writes 0x20080005@0x0, 0x20090007@0x4, then done=1, cpu_hold=0.
REQ-034 Start, bytes 00 00 -> no wr_en, done=1 two cycles after LEN_LO byte accepted.
REQ-035 DEPTH=64, start, bytes 00 41 -> err=1, cpu_hold=1, no wr_en, byte_ready=0.
REQ-036 N=1 stream with byte_valid low 3 cycles between every byte -> single write of correct word; wr_en pulse one cycle wide.
REQ-037 reset=0 after 2 data bytes of word 1 -> all outputs at REQ-030 values; fresh session writes from BASE_ADDR.
REQ-038 With IMEM_LOADER_CHECKSUM_EN, N=1 word 0x12345678, checksum 0x08 -> done=1; checksum 0x09 -> err=1.

Source files
------------

// File: rtl/imem_loader.sv
// Streams a length-prefixed big-endian program into instruction memory and holds the CPU while loading.
// Optional `IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte; all outputs are registered.
module imem_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ERR,
    CSUM
`else
    ERR
`endif
  } state_t;

  state_t      state;
  logic [15:0] len_n;
  logic        len_got;
  logic [23:0] part;
  logic [1:0]  byte_cnt;
  logic [15:0] idx;
  logic [15:0] idx_nxt;
  logic        take;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign take    = byte_valid && byte_ready;
  assign idx_nxt = idx + 16'd1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b1;
      len_n      <= 16'd0;
      len_got    <= 1'b0;
      part       <= 24'd0;
      byte_cnt   <= 2'd0;
      idx        <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN_HI;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            len_got    <= 1'b0;
            byte_cnt   <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
          end
        end
        LEN_HI: begin
          if (take) begin
            len_n[15:8] <= byte_data;
            state       <= LEN_LO;
          end
        end
        LEN_LO: begin
          // Low byte is latched first; the count is judged on the following cycle.
          if (!len_got) begin
            if (take) begin
              len_n[7:0] <= byte_data;
              len_got    <= 1'b1;
              byte_ready <= 1'b0;
            end
          end else begin
            len_got <= 1'b0;
            if (len_n == 16'd0) begin
              state    <= DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
            end else if ({16'd0, len_n} > 32'(DEPTH)) begin
              state    <= ERR;
              err      <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b1;
            end else begin
              state      <= DATA;
              byte_ready <= 1'b1;
              idx        <= 16'd0;
              byte_cnt   <= 2'd0;
            end
          end
        end
        DATA: begin
          if (take) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
            if (byte_cnt == 2'd3) begin
              wr_data    <= {part, byte_data};
              wr_addr    <= BASE_ADDR + {14'd0, idx, 2'b00};
              wr_en      <= 1'b1;
              byte_ready <= 1'b0;
              byte_cnt   <= 2'd0;
              state      <= WRITE;
            end else begin
              part     <= {part[15:0], byte_data};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          idx <= idx_nxt;
          if (idx_nxt == len_n) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= CSUM;
            byte_ready <= 1'b1;
`else
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
`endif
          end else begin
            state      <= DATA;
            byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (take) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            if (byte_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= ERR;
              err      <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts writes and outcome per session.
module tb_imem_loader;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, wr_en, cpu_hold, busy, done, err;
  logic [31:0] wr_addr, wr_data;

  always #5 clock = ~clock;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int         n_chk = 0;
  int         n_fail = 0;
  int         writes_seen = 0;
  wr_t        exp_q[$];
  logic [7:0] stream[$];
  bit         exp_done, exp_err;
  logic       prev_wr_en = 1'b0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Whole-stream model: count, big-endian words at consecutive addresses, optional XOR trailer.
  task automatic model_session();
    int n;
    logic [7:0] x;
    wr_t w;
    n = {stream[0], stream[1]};
    x = 8'd0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n == 0) exp_done = 1'b1;
    else if (n > DEPTH) exp_err = 1'b1;
    else begin
      for (int i = 0; i < n; i++) begin
        w.addr = BASE + 32'(4 * i);
        w.data = {stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]};
        x = x ^ stream[2+4*i] ^ stream[3+4*i] ^ stream[4+4*i] ^ stream[5+4*i];
        exp_q.push_back(w);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (stream[2+4*n] == x) exp_done = 1'b1;
      else exp_err = 1'b1;
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  wr_t got_w;
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (wr_en) begin
        writes_seen++;
        check1("wr_en_one_cycle", prev_wr_en, 1'b0);
        check1("wr_en_while_busy", busy, 1'b1);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
        end else begin
          got_w = exp_q.pop_front();
          check32("wr_addr", wr_addr, got_w.addr);
          check32("wr_data", wr_data, got_w.data);
        end
      end
      if (!busy) check1("ready_when_idle", byte_ready, 1'b0);
    end
    prev_wr_en = wr_en;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int t;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clock);
    byte_valid = 1'b1;
    byte_data  = b;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 200) begin
      acc = byte_ready;
      @(negedge clock);
      t++;
    end
    byte_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL byte_timeout: byte %h not accepted within 200 cycles", b);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check1("start_busy", busy, 1'b1);
    check1("start_done_clr", done, 1'b0);
    check1("start_err_clr", err, 1'b0);
    check1("start_hold", cpu_hold, 1'b1);
    check1("start_ready", byte_ready, 1'b1);
  endtask

  task automatic check_end();
    int t;
    t = 0;
    while (busy && t < 50) begin
      @(negedge clock);
      t++;
    end
    check1("end_not_busy", busy, 1'b0);
    check1("end_done", done, exp_done);
    check1("end_err", err, exp_err);
    check1("end_hold", cpu_hold, exp_err);
    check1("end_ready", byte_ready, 1'b0);
    check32("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_stream(input int gap);
    foreach (stream[i]) send_byte(stream[i], gap);
  endtask

  task automatic check_reset_vals();
    check1("rst_ready", byte_ready, 1'b0);
    check1("rst_wr_en", wr_en, 1'b0);
    check32("rst_wr_addr", wr_addr, BASE);
    check32("rst_wr_data", wr_data, 32'd0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    check1("rst_hold", cpu_hold, 1'b1);
  endtask

  int base_w;

  initial begin
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
    repeat (3) @(negedge clock);
    check_reset_vals();
    reset = 1'b1;
    @(negedge clock);

    // Two-word program.
    stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h03);
`endif
    model_session();
    check32("model_w0", exp_q[0].data, 32'h2008_0005);
    check32("model_a1", exp_q[1].addr, 32'h0000_0004);
    base_w = writes_seen;
    pulse_start();
    send_stream(0);
    check_end();
    check32("two_writes", 32'(writes_seen - base_w), 32'd2);

    // Empty program: done two cycles after the low count byte.
    stream = '{8'h00, 8'h00};
    model_session();
    pulse_start();
    send_stream(0);
    check1("n0_done_early", done, 1'b0);
    @(negedge clock);
    check1("n0_done", done, 1'b1);
    check1("n0_hold", cpu_hold, 1'b0);
    check_end();

    // Count one past capacity.
    stream = '{8'h00, 8'h41};
    model_session();
    check1("model_err65", exp_err, 1'b1);
    base_w = writes_seen;
    pulse_start();
    send_stream(0);
    check_end();
    check32("n65_no_write", 32'(writes_seen - base_w), 32'd0);

    // Single word with 3-cycle valid gaps between every byte.
    stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h22);
`endif
    model_session();
    pulse_start();
    send_stream(3);
    check_end();

    // Full capacity: 64 words, last at 0xFC.
    stream = '{8'h00, 8'h40};
    for (int k = 0; k < 256; k++) stream.push_back(8'(k));
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    model_session();
    check32("model_last_addr", exp_q[63].addr, 32'h0000_00FC);
    check32("model_last_data", exp_q[63].data, 32'hFCFD_FEFF);
    pulse_start();
    send_stream(0);
    check_end();

    // High count byte carries weight 256.
    stream = '{8'h01, 8'h00};
    model_session();
    pulse_start();
    send_stream(0);
    check_end();

    // Reset in the middle of the second word.
    stream = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_q.push_back('{addr: BASE, data: 32'h1122_3344});
    base_w = writes_seen;
    pulse_start();
    send_stream(0);
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals();
    reset = 1'b1;
    @(negedge clock);
    check32("mid_rst_writes", 32'(writes_seen - base_w), 32'd1);
    check32("mid_rst_pending", 32'(exp_q.size()), 32'd0);
    stream = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h30);
`endif
    model_session();
    check32("model_fresh_addr", exp_q[0].addr, BASE);
    pulse_start();
    send_stream(1);
    check_end();

`ifdef IMEM_LOADER_CHECKSUM_EN
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    model_session();
    check1("model_csum_ok", exp_done, 1'b1);
    pulse_start();
    send_stream(0);
    check_end();
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    model_session();
    check1("model_csum_bad", exp_err, 1'b1);
    pulse_start();
    send_stream(0);
    check_end();
`endif

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
